ds2411_responder: RTL

Single-clock 1-Wire slave that emulates a DS2411 silicon serial number on an open-drain DQ line. It is the device-side counterpart to the `read_ds2411` bus master, for loopback benches and for boards where the physical DS2411 is absent. It handles four things: reset pulse detection, presence pulse generation, command byte reception, and the Read ROM (0x33/0x0F) and Search ROM (0xF0) responses. The ROM CRC is computed on the fly.

---
 rtl/ds2411_responder_if.sv | 11 +
 rtl/ds2411_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ds2411_responder_if.sv
// DQ-side signal bundle of the DS2411 emulator: the slave modport is the
// device, the master modport is the bus master (or a bench).
interface ds2411_responder_if;
  logic       dq_in;
  logic       dq_oe;
  logic [7:0] cmd;
  logic       busy;

  modport master (output dq_in, input dq_oe, cmd, busy);
  modport slave  (input dq_in, output dq_oe, cmd, busy);
endinterface

// File: rtl/ds2411_responder.sv
// 1-Wire slave emulating a DS2411 serial number: reset/presence, command
// reception, Read ROM and Search ROM with the CRC built on the fly.
module ds2411_responder #(
  parameter int unsigned CLK_MHZ = 100,
  parameter logic [7:0]  FAMILY  = 8'h01,
  parameter logic [47:0] SERIAL  = 48'h000000000001
) (
  input logic               clk,
  input logic               reset,
  ds2411_responder_if.slave bus
);

  localparam int unsigned T_RSTL = 440 * CLK_MHZ;
  localparam int unsigned T_PDH  = 30  * CLK_MHZ;
  localparam int unsigned T_PDL  = 120 * CLK_MHZ;
  localparam int unsigned T_SAMP = 30  * CLK_MHZ;
  localparam int unsigned T_DRV0 = 30  * CLK_MHZ;
  // Presence wait absorbs the synchronizer and edge-detect latency.
  localparam int unsigned PD_WAIT_CYC = (T_PDH > 3) ? (T_PDH - 3) : 1;

  localparam int unsigned LW = $clog2(T_RSTL + 1);
  localparam int unsigned TW = $clog2(T_PDL + 1);

  localparam logic [LW-1:0] RSTL_HIT = LW'(T_RSTL - 1);
  localparam logic [LW-1:0] RSTL_SAT = LW'(T_RSTL);
  localparam logic [TW-1:0] PDH_END  = TW'(PD_WAIT_CYC - 1);
  localparam logic [TW-1:0] PDL_END  = TW'(T_PDL - 1);
  localparam logic [TW-1:0] SAMP_END = TW'(T_SAMP - 1);
  localparam logic [TW-1:0] DRV0_END = TW'(T_DRV0 - 1);

  localparam logic [55:0] ROM_ID = {SERIAL, FAMILY};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_PD_WAIT,
    S_PD_DRIVE,
    S_CMD,
    S_ROM_TX,
    S_SEARCH,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, dqs_q, dqs_prev_q;
  logic [LW-1:0] lowcnt_q, lowcnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          slot_q, slot_d;
  logic [5:0]    nbit_q, nbit_d;
  logic [1:0]    sph_q, sph_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    crc_q, crc_d;
  logic          dq_oe_q, dq_oe_d;
  logic          busy_q, busy_d;

  logic          fall, rise, force_rst;
  logic          rom_bit, send_bit, is_write;
  logic [TW-1:0] slot_end;
  logic          bit_done, bit_val;

  function automatic logic [7:0] crc_step(logic [7:0] c, logic b);
    logic fb;
    fb = c[0] ^ b;
    return {fb, c[7:1]} ^ (fb ? 8'h0C : 8'h00);
  endfunction

  always_comb begin
    fall      = dqs_prev_q & ~dqs_q;
    rise      = ~dqs_prev_q & dqs_q;
    force_rst = ~dqs_q && (lowcnt_q >= RSTL_HIT);
    if (dqs_q)                     lowcnt_d = '0;
    else if (lowcnt_q == RSTL_SAT) lowcnt_d = lowcnt_q;
    else                           lowcnt_d = lowcnt_q + 1'b1;

    rom_bit  = (nbit_q < 6'd56) ? ROM_ID[nbit_q] : crc_q[nbit_q[2:0]];
    is_write = (state_q == S_CMD) || ((state_q == S_SEARCH) && (sph_q == 2'd2));
    send_bit = ((state_q == S_SEARCH) && (sph_q == 2'd1)) ? ~rom_bit : rom_bit;
    slot_end = is_write ? SAMP_END : DRV0_END;
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    slot_d   = slot_q;
    nbit_d   = nbit_q;
    sph_d    = sph_q;
    sh_d     = sh_q;
    cmd_d    = cmd_q;
    crc_d    = crc_q;
    bit_done = 1'b0;
    bit_val  = 1'b0;

    case (state_q)
      S_RST_LOW: begin
        if (rise) begin
          state_d = S_PD_WAIT;
          tmr_d   = '0;
        end
      end
      S_PD_WAIT: begin
        if (tmr_q == PDH_END) begin
          state_d = S_PD_DRIVE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_PD_DRIVE: begin
        if (tmr_q == PDL_END) begin
          state_d = S_CMD;
          tmr_d   = '0;
          slot_d  = 1'b0;
          nbit_d  = '0;
          sh_d    = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_CMD, S_ROM_TX, S_SEARCH: begin
        // A read-1 slot needs no drive, so it completes on the edge itself;
        // edges inside a running slot window are ignored.
        if (slot_q) begin
          if (tmr_q == slot_end) begin
            slot_d   = 1'b0;
            bit_done = 1'b1;
            bit_val  = dqs_q;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end else if (fall) begin
          if (is_write || !send_bit) begin
            slot_d = 1'b1;
            tmr_d  = '0;
          end else begin
            bit_done = 1'b1;
            bit_val  = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (bit_done && !force_rst) begin
      case (state_q)
        S_CMD: begin
          sh_d   = {bit_val, sh_q[7:1]};
          nbit_d = nbit_q + 1'b1;
          if (nbit_q == 6'd7) begin
            cmd_d  = sh_d;
            nbit_d = '0;
            sph_d  = '0;
            crc_d  = '0;
            case (sh_d)
              8'h33, 8'h0F: state_d = S_ROM_TX;
              8'hF0:        state_d = S_SEARCH;
              default:      state_d = S_DONE;
            endcase
          end
        end
        S_ROM_TX: begin
          if (nbit_q < 6'd56) crc_d = crc_step(crc_q, rom_bit);
          nbit_d = nbit_q + 1'b1;
          if (nbit_q == 6'd63) state_d = S_DONE;
        end
        S_SEARCH: begin
          case (sph_q)
            2'd0: sph_d = 2'd1;
            2'd1: sph_d = 2'd2;
            default: begin
              sph_d = 2'd0;
              if (bit_val != rom_bit) begin
                state_d = S_DONE;
              end else begin
                if (nbit_q < 6'd56) crc_d = crc_step(crc_q, rom_bit);
                nbit_d = nbit_q + 1'b1;
                if (nbit_q == 6'd63) state_d = S_DONE;
              end
            end
          endcase
        end
        default: ;
      endcase
    end

    if (force_rst) begin
      state_d = S_RST_LOW;
      slot_d  = 1'b0;
      tmr_d   = '0;
    end

    dq_oe_d = (state_d == S_PD_DRIVE) || (slot_d && !is_write);
    busy_d  = (state_d == S_CMD) || (state_d == S_ROM_TX) || (state_d == S_SEARCH);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      dqs_q      <= 1'b1;
      dqs_prev_q <= 1'b1;
      lowcnt_q   <= '0;
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      slot_q     <= 1'b0;
      nbit_q     <= '0;
      sph_q      <= '0;
      sh_q       <= '0;
      cmd_q      <= '0;
      crc_q      <= '0;
      dq_oe_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= bus.dq_in;
      dqs_q      <= sync1_q;
      dqs_prev_q <= dqs_q;
      lowcnt_q   <= lowcnt_d;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      slot_q     <= slot_d;
      nbit_q     <= nbit_d;
      sph_q      <= sph_d;
      sh_q       <= sh_d;
      cmd_q      <= cmd_d;
      crc_q      <= crc_d;
      dq_oe_q    <= dq_oe_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.dq_oe = dq_oe_q;
  assign bus.cmd   = cmd_q;
  assign bus.busy  = busy_q;

endmodule
